spn_cu_driver: RTL and testbench
================================

# spn_cu_driver

Requester-side sequencer for the SPN cryptographic unit. It accepts one job at a time over a valid/ready request channel, drives the unit's `opcode`/`in_data`/`key` inputs with correct key-setup and capture timing, and checks the returned response code. It can also run an encrypt-then-decrypt round-trip self-check. Results go back over a valid/ready response channel, and a saturating error counter is kept. It sits between the system-side job source and one SPN unit instance.

## Interface
Parameters:
- `CNT_W`, 8: width of the error counter.

Ports:
- `clk`  in  1: single clock. The SPN unit uses the same clock.
- `reset`  in  1: asynchronous, active-low reset (asserted at 0).
- `req_valid`  in  1: job request valid.
- `req_ready`  out  1: driver can accept a job.
- `req_mode`  in  2: 00 ENC, 01 DEC, 10 ROUNDTRIP, 11 illegal.
- `req_data`  in  16: plaintext or ciphertext.
- `req_key`  in  32: job key.
- `rsp_valid`  out  1: result valid.
- `rsp_ready`  in  1: consumer accepts result.
- `rsp_data`  out  16: result block.
- `rsp_status`  out  2: 00 OK, 01 response-code mismatch, 10 round-trip compare fail, 11 illegal mode.
- `err_count`  out  CNT_W: saturating count of non-OK responses.
- `spn_opcode`  out  2: to SPN unit. OP_NOP=00, OP_ENC=01, OP_DEC=10, OP_ERR=11.
- `spn_in_data`  out  16: to SPN unit.
- `spn_key`  out  32: to SPN unit.
- `spn_out_data`  in  16: from SPN unit.
- `spn_valid`  in  2: response code from SPN unit.

## Operation
- FSM states: IDLE, KEY, ISSUE, CAPTURE, ISSUE2, CAPTURE2, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid` && `req_ready`, latch mode, data and key.
  - Mode 11: go to RESP with status 11 and `rsp_data`=0. Nothing is issued to the SPN unit.
  - Any other mode: go to KEY.
- KEY
  - `spn_key` = latched key; `spn_opcode` = OP_NOP.
  - This cycle lets the SPN unit register its round keys.
- ISSUE
  - `spn_opcode` = OP_ENC for modes ENC and ROUNDTRIP, OP_DEC for mode DEC.
  - `spn_in_data` = latched data.
- CAPTURE
  - `spn_opcode` = OP_NOP.
  - Sample `spn_out_data` and `spn_valid`.
  - If `spn_valid` != the opcode issued, set status 01.
  - ENC/DEC: go to RESP.
  - ROUNDTRIP with no mismatch: go to ISSUE2. With a mismatch: go to RESP.
- ISSUE2
  - `spn_opcode` = OP_DEC; `spn_in_data` = ciphertext captured in CAPTURE.
- CAPTURE2
  - Sample as in CAPTURE; expected code is OP_DEC, mismatch gives status 01.
  - Otherwise compare the decrypted block with the original data. Unequal gives status 10; equal gives 00.
  - `rsp_data` = decrypted block.
- RESP
  - Hold `rsp_valid`=1 and stable `rsp_data`/`rsp_status` until `rsp_ready`, then return to IDLE.
  - On acceptance of a non-OK response, `err_count` increments. It saturates at all-ones.
- `spn_opcode` is OP_NOP in every state except ISSUE and ISSUE2.
- `spn_key` holds the latched key from KEY through CAPTURE2, so a round-trip uses the same key for both passes.
- `spn_in_data` and `spn_key` keep their last values when not in use; they do not return to 0.
- An SPN response code of OP_ERR or OP_NOP in a capture state is treated as a mismatch.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1, `rsp_valid`=0;
  - `rsp_data`=0, `rsp_status`=00, `err_count`=0;
  - `spn_opcode`=OP_NOP, `spn_in_data`=0, `spn_key`=0.
- Cycle counts, with the request accepted at edge 0:
  - ENC/DEC: KEY in cycle 1, ISSUE in 2, CAPTURE in 3, `rsp_valid` from cycle 4.
  - ROUNDTRIP: ISSUE2 in 4, CAPTURE2 in 5, `rsp_valid` from cycle 6.
  - Illegal mode: `rsp_valid` from cycle 1.
- SPN unit latency is exactly one cycle: opcode in cycle N, response sampled in cycle N+1. There is no timeout.
- `req_ready` is 0 outside IDLE. A request cannot be accepted in the same cycle a response is accepted; IDLE is re-entered first.
- Reset asserted mid-job aborts immediately to the reset values; no response is produced for that job.
- Counter saturation: at all-ones, further non-OK responses leave `err_count` unchanged.

## Test plan
- ENC, data 16'h1234, key 32'hDEADBEEF, real SPN unit, `rsp_ready`=1
  -> `spn_opcode`=01 only in cycle 2; `rsp_valid` in cycle 4; status 00; `rsp_data` equals the reference model's encryption.
- ROUNDTRIP, data 16'h1234, key 32'hDEADBEEF
  -> `rsp_data`=16'h1234, status 00 in cycle 6; `spn_opcode` sequence 00,01,00,10,00.
- Stub SPN that returns `spn_valid`=11 on ENC
  -> status 01, `err_count` goes 0→1 on acceptance; ROUNDTRIP stops after CAPTURE with no ISSUE2.
- Stub SPN whose decryption corrupts bit 0, ROUNDTRIP data 16'hA5A5
  -> status 10, `rsp_data`=16'hA5A4.
- Mode 11
  -> `rsp_valid` next cycle, status 11, `spn_opcode` stays 00. Hold `rsp_ready`=0 for 5 cycles -> outputs stable, `req_ready`=0.
- Drive `reset` low during ISSUE of a DEC job
  -> all outputs at reset values at once; the next job completes normally. With `CNT_W`=2, 4 illegal jobs -> `err_count`=3.

Source files
------------

// File: rtl/spn_cu_driver.sv
// spn_cu_driver: requester-side sequencer for one SPN cryptographic unit.
// It accepts one job at a time and drives the key-setup, issue and capture
// cycles. It can run an encrypt-then-decrypt round-trip self-check, and it
// returns results over a valid/ready channel while keeping a saturating
// error count.
module spn_cu_driver #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [15:0]      req_data,
    input  logic [31:0]      req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [1:0]       rsp_status,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       spn_opcode,
    output logic [15:0]      spn_in_data,
    output logic [31:0]      spn_key,
    input  logic [15:0]      spn_out_data,
    input  logic [1:0]       spn_valid
);

    localparam logic [1:0] MODE_ENC = 2'b00;
    localparam logic [1:0] MODE_DEC = 2'b01;
    localparam logic [1:0] MODE_RT  = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_MIS  = 2'b01;
    localparam logic [1:0] ST_CMP  = 2'b10;
    localparam logic [1:0] ST_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY      = 3'd1,
        S_ISSUE    = 3'd2,
        S_CAPTURE  = 3'd3,
        S_ISSUE2   = 3'd4,
        S_CAPTURE2 = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;

    // Job fields latched at acceptance; only meaningful while a job is active.
    logic [1:0]       r_mode;
    logic [15:0]      r_data;

    logic [15:0]      r_rsp_data;
    logic [1:0]       r_rsp_status;
    logic [CNT_W-1:0] r_err_count;
    logic [15:0]      r_spn_in_data;
    logic [31:0]      r_spn_key;

    logic             w_req_ready;
    logic             w_rsp_valid;
    logic [1:0]       w_spn_opcode;
    logic             w_accept;
    logic             w_rsp_accept;
    logic [1:0]       w_issue_op;
    logic             w_cap_mismatch;
    logic             w_cap2_mismatch;
    logic             w_rsp_err;
    logic             w_cnt_full;

    assign w_accept        = (r_state == S_IDLE) && req_valid;
    assign w_rsp_accept    = (r_state == S_RESP) && rsp_ready;
    // First-pass opcode: only DEC jobs decrypt first; ENC and ROUNDTRIP encrypt.
    assign w_issue_op      = (r_mode == MODE_DEC) ? OP_DEC : OP_ENC;
    // Any code other than the one issued (including NOP/ERR) is a mismatch.
    assign w_cap_mismatch  = (spn_valid != w_issue_op);
    assign w_cap2_mismatch = (spn_valid != OP_DEC);
    assign w_rsp_err       = (r_rsp_status != ST_OK);
    assign w_cnt_full      = &r_err_count;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        w_next       = r_state;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_spn_opcode = OP_NOP;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (req_mode == MODE_ILL) ? S_RESP : S_KEY;
                end
            end
            S_KEY: begin
                w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_spn_opcode = w_issue_op;
                w_next       = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = ((r_mode == MODE_RT) && !w_cap_mismatch) ? S_ISSUE2 : S_RESP;
            end
            S_ISSUE2: begin
                w_spn_opcode = OP_DEC;
                w_next       = S_CAPTURE2;
            end
            S_CAPTURE2: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch the job's mode and data on acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mode <= req_mode;
            r_data <= req_data;
        end
    end

    // SPN drive registers and response capture. The key and input block
    // persist between jobs so the unit's inputs only change when used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_data    <= 16'd0;
            r_rsp_status  <= ST_OK;
            r_spn_in_data <= 16'd0;
            r_spn_key     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_mode == MODE_ILL) begin
                            r_rsp_data   <= 16'd0;
                            r_rsp_status <= ST_ILL;
                        end else begin
                            // Key is presented during KEY so the unit can
                            // expand it before the first issue.
                            r_spn_key <= req_key;
                        end
                    end
                end
                S_KEY: begin
                    r_spn_in_data <= r_data;
                end
                S_CAPTURE: begin
                    r_rsp_data   <= spn_out_data;
                    r_rsp_status <= w_cap_mismatch ? ST_MIS : ST_OK;
                    if ((r_mode == MODE_RT) && !w_cap_mismatch) begin
                        // Feed the ciphertext straight back for the decrypt pass.
                        r_spn_in_data <= spn_out_data;
                    end
                end
                S_CAPTURE2: begin
                    r_rsp_data <= spn_out_data;
                    if (w_cap2_mismatch) begin
                        r_rsp_status <= ST_MIS;
                    end else if (spn_out_data != r_data) begin
                        r_rsp_status <= ST_CMP;
                    end else begin
                        r_rsp_status <= ST_OK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating count of non-OK responses, stepped when the consumer accepts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (w_rsp_accept && w_rsp_err && !w_cnt_full) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = w_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_status  = r_rsp_status;
    assign err_count   = r_err_count;
    assign spn_opcode  = w_spn_opcode;
    assign spn_in_data = r_spn_in_data;
    assign spn_key     = r_spn_key;

endmodule

// File: tb/tb_spn_cu_driver.sv
// Testbench for spn_cu_driver: a behavioural SPN unit with fault injection,
// table vectors, a reset abort sequence, random jobs and counter saturation.
module tb_spn_cu_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic [1:0]  req_mode;
    logic [15:0] req_data;
    logic [31:0] req_key;
    logic        rsp_ready;
    wire         req_ready;
    wire         rsp_valid;
    wire  [15:0] rsp_data;
    wire  [1:0]  rsp_status;
    wire  [7:0]  err_count;
    wire  [1:0]  spn_opcode;
    wire  [15:0] spn_in_data;
    wire  [31:0] spn_key;
    logic [15:0] spn_out_data = 16'd0;
    logic [1:0]  spn_valid    = 2'b00;

    wire         d2_req_ready;
    wire         d2_rsp_valid;
    wire  [15:0] d2_rsp_data;
    wire  [1:0]  d2_rsp_status;
    wire  [1:0]  d2_err_count;
    wire  [1:0]  d2_spn_opcode;
    wire  [15:0] d2_spn_in_data;
    wire  [31:0] d2_spn_key;

    spn_cu_driver #(.CNT_W(8)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .err_count(err_count),
        .spn_opcode(spn_opcode), .spn_in_data(spn_in_data), .spn_key(spn_key),
        .spn_out_data(spn_out_data), .spn_valid(spn_valid)
    );

    // Second instance with a 2-bit counter, driven identically.
    spn_cu_driver #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(d2_req_ready), .req_mode(req_mode),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(d2_rsp_data),
        .rsp_status(d2_rsp_status), .err_count(d2_err_count),
        .spn_opcode(d2_spn_opcode), .spn_in_data(d2_spn_in_data), .spn_key(d2_spn_key),
        .spn_out_data(spn_out_data), .spn_valid(spn_valid)
    );

    function automatic logic [15:0] enc(input logic [15:0] x, input logic [31:0] k);
        logic [15:0] y;
        y = x ^ k[15:0];
        y = {y[12:0], y[15:13]};
        return y + k[31:16];
    endfunction

    function automatic logic [15:0] dec(input logic [15:0] x, input logic [31:0] k);
        logic [15:0] y;
        y = x - k[31:16];
        y = {y[2:0], y[15:3]};
        return y ^ k[15:0];
    endfunction

    // Behavioural SPN unit: key registered every cycle, one-cycle response.
    logic        sb_fv = 1'b0;
    logic        sb_fb = 1'b0;
    logic [31:0] sb_rk = 32'd0;
    always @(posedge clk) begin
        sb_rk <= spn_key;
        case (spn_opcode)
            2'b01: begin
                spn_out_data <= enc(spn_in_data, sb_rk);
                spn_valid    <= sb_fv ? 2'b11 : 2'b01;
            end
            2'b10: begin
                spn_out_data <= dec(spn_in_data, sb_rk) ^ {15'd0, sb_fb};
                spn_valid    <= 2'b10;
            end
            default: spn_valid <= spn_opcode;
        endcase
    end

    int total = 0;
    int bad   = 0;
    int tb_err = 0;
    logic [31:0] tb_last_key = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome of a job from the driver's documented rules.
    function automatic void model_job(input logic [1:0] mode, input logic [15:0] data,
                                      input logic [31:0] key, input bit fv, input bit fb,
                                      output logic [1:0] st, output logic [15:0] d,
                                      output bit dchk, output int lat, output logic [11:0] ops);
        logic [15:0] pt;
        dchk = 1'b1;
        d    = 16'd0;
        case (mode)
            2'b00: begin
                lat = 4; ops = 12'h100;
                if (fv) begin st = 2'b01; dchk = 1'b0; end
                else begin st = 2'b00; d = enc(data, key); end
            end
            2'b01: begin
                lat = 4; ops = 12'h200; st = 2'b00;
                d = dec(data, key) ^ {15'd0, fb};
            end
            2'b10: begin
                if (fv) begin
                    lat = 4; ops = 12'h100; st = 2'b01; dchk = 1'b0;
                end else begin
                    lat = 6; ops = 12'h120;
                    pt = dec(enc(data, key), key) ^ {15'd0, fb};
                    d  = pt;
                    st = (pt == data) ? 2'b00 : 2'b10;
                end
            end
            default: begin
                lat = 1; ops = 12'h000; st = 2'b11; d = 16'd0;
            end
        endcase
    endfunction

    // Issue one job, trace opcodes for cycles 1..6, hold rsp_ready low until
    // at least cycle 6 and hold cycles past first rsp_valid, then accept.
    task automatic run_job(input logic [1:0] mode, input logic [15:0] data,
                           input logic [31:0] key, input int hold,
                           output int lat, output logic [11:0] ops, output logic [1:0] st,
                           output logic [15:0] d, output bit stable, output logic [31:0] key_a);
        lat = 0; ops = 12'h000; st = 2'b00; d = 16'd0; stable = 1'b1; key_a = 32'd0;
        @(negedge clk);
        req_valid = 1'b1; req_mode = mode; req_data = data; req_key = key;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 6) ops = {ops[9:0], spn_opcode};
            if (lat == 0 && rsp_valid) begin
                lat = k; st = rsp_status; d = rsp_data; key_a = spn_key;
            end else if (lat != 0) begin
                if (!rsp_valid || rsp_status != st || rsp_data != d || req_ready) stable = 1'b0;
            end
            if (lat != 0 && k >= 6 && k >= lat + hold) begin
                rsp_ready = 1'b1;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_check(input string tag, input logic [1:0] mode, input logic [15:0] data,
                            input logic [31:0] key, input bit fv, input bit fb, input int hold,
                            input logic [1:0] e_st, input logic [15:0] e_d, input bit dchk,
                            input int e_lat, input logic [11:0] e_ops);
        int          lat_a;
        logic [11:0] ops_a;
        logic [1:0]  st_a;
        logic [15:0] d_a;
        bit          stable;
        logic [31:0] key_a;
        logic [31:0] e_key;
        sb_fv = fv; sb_fb = fb;
        run_job(mode, data, key, hold, lat_a, ops_a, st_a, d_a, stable, key_a);
        e_key = (mode == 2'b11) ? tb_last_key : key;
        if (mode != 2'b11) tb_last_key = key;
        if (e_st != 2'b00) tb_err++;
        chk({tag, ".lat"}, lat_a, e_lat);
        chk({tag, ".ops"}, ops_a, e_ops);
        chk({tag, ".status"}, st_a, e_st);
        if (dchk) chk({tag, ".data"}, d_a, e_d);
        chk({tag, ".stable"}, stable, 1'b1);
        chk({tag, ".key"}, key_a, e_key);
        @(negedge clk);
        chk({tag, ".idle_ready"}, {req_ready, rsp_valid}, 2'b10);
        chk({tag, ".err8"}, err_count, (tb_err > 255) ? 255 : tb_err);
        chk({tag, ".err2"}, d2_err_count, (tb_err > 3) ? 3 : tb_err);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req_ready"}, req_ready, 1'b1);
        chk({tag, ".rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, ".rsp_data"}, rsp_data, 16'd0);
        chk({tag, ".rsp_status"}, rsp_status, 2'b00);
        chk({tag, ".err_count"}, err_count, 8'd0);
        chk({tag, ".spn_opcode"}, spn_opcode, 2'b00);
        chk({tag, ".spn_in_data"}, spn_in_data, 16'd0);
        chk({tag, ".spn_key"}, spn_key, 32'd0);
        chk({tag, ".err2"}, d2_err_count, 2'd0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] data;
        logic [31:0] key;
        bit          fv;
        bit          fb;
        int          hold;
        logic [1:0]  st;
        logic [15:0] d;
        bit          dchk;
        int          lat;
        logic [11:0] ops;
    } vec_t;

    vec_t vt [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m, e_st;
        logic [15:0] dd, e_d;
        logic [31:0] kk;
        bit          fv, fb, dchk;
        int          e_lat;
        logic [11:0] e_ops;

        vt[0] = '{2'b00, 16'h1234, 32'hDEADBEEF, 1'b0, 1'b0, 0, 2'b00, enc(16'h1234, 32'hDEADBEEF), 1'b1, 4, 12'h100};
        vt[1] = '{2'b10, 16'h1234, 32'hDEADBEEF, 1'b0, 1'b0, 2, 2'b00, 16'h1234, 1'b1, 6, 12'h120};
        vt[2] = '{2'b01, 16'h9C3E, 32'h01234567, 1'b0, 1'b0, 1, 2'b00, dec(16'h9C3E, 32'h01234567), 1'b1, 4, 12'h200};
        vt[3] = '{2'b00, 16'h1234, 32'hDEADBEEF, 1'b1, 1'b0, 0, 2'b01, 16'h0000, 1'b0, 4, 12'h100};
        vt[4] = '{2'b10, 16'h0F0F, 32'hCAFEF00D, 1'b1, 1'b0, 0, 2'b01, 16'h0000, 1'b0, 4, 12'h100};
        vt[5] = '{2'b10, 16'hA5A5, 32'h13579BDF, 1'b0, 1'b1, 0, 2'b10, 16'hA5A4, 1'b1, 6, 12'h120};
        vt[6] = '{2'b11, 16'h7777, 32'hFFFFFFFF, 1'b0, 1'b0, 5, 2'b11, 16'h0000, 1'b1, 1, 12'h000};
        vt[7] = '{2'b01, 16'hBEEF, 32'h2468ACE0, 1'b1, 1'b0, 3, 2'b00, dec(16'hBEEF, 32'h2468ACE0), 1'b1, 4, 12'h200};

        reset = 1'b0; req_valid = 1'b0; req_mode = 2'b00; req_data = 16'd0;
        req_key = 32'd0; rsp_ready = 1'b0;
        #12;
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_check($sformatf("vec%0d", i), vt[i].mode, vt[i].data, vt[i].key, vt[i].fv,
                     vt[i].fb, vt[i].hold, vt[i].st, vt[i].d, vt[i].dchk, vt[i].lat, vt[i].ops);
        end

        // Reset asserted while a DEC job is in ISSUE.
        sb_fv = 1'b0; sb_fb = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_mode = 2'b01; req_data = 16'h5A5A; req_key = 32'h0BADF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.issue_op", spn_opcode, 2'b10);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        chk("midrst.held", {req_ready, rsp_valid}, 2'b10);
        reset = 1'b1;
        tb_err = 0;
        tb_last_key = 32'd0;
        repeat (3) @(negedge clk);
        chk("midrst.no_rsp", rsp_valid, 1'b0);
        model_job(2'b01, 16'h5A5A, 32'h0BADF00D, 1'b0, 1'b0, e_st, e_d, dchk, e_lat, e_ops);
        do_check("after_rst", 2'b01, 16'h5A5A, 32'h0BADF00D, 1'b0, 1'b0, 0,
                 e_st, e_d, dchk, e_lat, e_ops);

        for (int i = 0; i < 40; i++) begin
            m  = 2'($urandom_range(0, 3));
            dd = 16'($urandom);
            kk = $urandom;
            fv = ($urandom_range(0, 3) == 0);
            fb = ($urandom_range(0, 3) == 0);
            model_job(m, dd, kk, fv, fb, e_st, e_d, dchk, e_lat, e_ops);
            do_check($sformatf("rnd%0d", i), m, dd, kk, fv, fb, int'($urandom_range(0, 3)),
                     e_st, e_d, dchk, e_lat, e_ops);
        end

        // Drive enough illegal jobs to saturate both counters.
        for (int i = 0; i < 260; i++) begin
            do_check($sformatf("sat%0d", i), 2'b11, 16'($urandom), $urandom, 1'b0, 1'b0, 0,
                     2'b11, 16'h0000, 1'b1, 1, 12'h000);
        end
        chk("sat.final8", err_count, 8'hFF);
        chk("sat.final2", d2_err_count, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
